// File: rtl/output_gain_stage.sv
// Purpose: converts a signed BCD tenths-of-dB setting to a linear Q3.13 gain and
//          applies it, per-sample ramped, with round-half-up and saturation.
// Latency: 2 cycles in_valid -> out_valid; setting takes 3 cycles; no backpressure.
module output_gain_stage #(
  parameter int RAMP_STEP      = 16,
  parameter int RESET_GAIN_IDX = 60
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               set,
  input  logic [3:0]         num2,
  input  logic [3:0]         num1,
  input  logic [3:0]         num0,
  input  logic               neg,
  input  logic               in_valid,
  input  logic signed [15:0] in_sample,
  output logic               out_valid,
  output logic signed [15:0] out_sample,
  output logic               clip,
  output logic               busy,
  output logic               bad_bcd,
  output logic [15:0]        gain
);

  // round(8192 * 10^((i-60)/20)) for i = 0..72, i.e. -60 dB .. +12 dB in 1 dB steps
  localparam logic [15:0] GAIN_LUT [0:72] = '{
    16'd8,     16'd9,     16'd10,    16'd12,    16'd13,    16'd15,    16'd16,    16'd18,
    16'd21,    16'd23,    16'd26,    16'd29,    16'd33,    16'd37,    16'd41,    16'd46,
    16'd52,    16'd58,    16'd65,    16'd73,    16'd82,    16'd92,    16'd103,   16'd116,
    16'd130,   16'd146,   16'd163,   16'd183,   16'd206,   16'd231,   16'd259,   16'd291,
    16'd326,   16'd366,   16'd411,   16'd461,   16'd517,   16'd580,   16'd651,   16'd730,
    16'd819,   16'd919,   16'd1031,  16'd1157,  16'd1298,  16'd1457,  16'd1635,  16'd1834,
    16'd2058,  16'd2309,  16'd2591,  16'd2907,  16'd3261,  16'd3659,  16'd4106,  16'd4607,
    16'd5169,  16'd5799,  16'd6507,  16'd7301,  16'd8192,  16'd9192,  16'd10313, 16'd11572,
    16'd12983, 16'd14568, 16'd16345, 16'd18340, 16'd20577, 16'd23088, 16'd25905, 16'd29066,
    16'd32613
  };

  localparam logic [15:0]        STEP_U = 16'(RAMP_STEP);
  localparam logic signed [16:0] STEP_S = 17'(RAMP_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SCALE,
    S_LOOKUP
  } state_t;

  // Setting path state
  state_t      state_q, state_d;
  logic [3:0]  d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
  logic        neg_q, neg_d;
  logic [9:0]  t_q, t_d;
  logic [6:0]  idx_q, idx_d;
  logic [15:0] target_q, target_d;
  logic        bad_bcd_q, bad_bcd_d;

  // Ramp and datapath state
  logic [15:0]        gain_q, gain_d;
  logic signed [32:0] prod_q, prod_d;
  logic               vld1_q, vld1_d;
  logic               out_vld_q, out_vld_d;
  logic signed [15:0] out_sample_q, out_sample_d;
  logic               clip_q, clip_d;

  // Intermediate combinational values
  logic               digit_bad;
  logic [9:0]         t_calc;
  logic signed [10:0] s_raw, s_clamp;
  logic [10:0]        s_off;
  logic signed [16:0] gain_diff;
  logic signed [33:0] rnd_sum, rnd_shift;

  // Decimal value of the latched digits and its signed, clamped, dB-rounded index
  always_comb begin
    digit_bad = (d2_q > 4'd9) || (d1_q > 4'd9) || (d0_q > 4'd9);
    t_calc    = {6'd0, d2_q} * 10'd100 + {6'd0, d1_q} * 10'd10 + {6'd0, d0_q};
    s_raw     = neg_q ? -$signed({1'b0, t_q}) : $signed({1'b0, t_q});
    if (s_raw < -11'sd600) begin
      s_clamp = -11'sd600;
    end else if (s_raw > 11'sd120) begin
      s_clamp = 11'sd120;
    end else begin
      s_clamp = s_raw;
    end
    // +605 shifts -60.0 dB to 5 so the divide by 10 rounds half up to whole dB
    s_off = 11'(s_clamp + 11'sd605);
  end

  // Setting FSM: IDLE -> CONV -> SCALE -> LOOKUP -> IDLE; set is ignored outside IDLE
  always_comb begin
    state_d   = state_q;
    d2_d      = d2_q;
    d1_d      = d1_q;
    d0_d      = d0_q;
    neg_d     = neg_q;
    t_d       = t_q;
    idx_d     = idx_q;
    target_d  = target_q;
    bad_bcd_d = bad_bcd_q;
    case (state_q)
      S_IDLE: begin
        if (set) begin
          d2_d    = num2;
          d1_d    = num1;
          d0_d    = num0;
          neg_d   = neg;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (digit_bad) begin
          bad_bcd_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          t_d       = t_calc;
          bad_bcd_d = 1'b0;
          state_d   = S_SCALE;
        end
      end
      S_SCALE: begin
        idx_d   = 7'(s_off / 11'd10);
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        target_d = GAIN_LUT[idx_q];
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Gain ramp: one bounded step toward the target per accepted sample
  always_comb begin
    gain_d    = gain_q;
    gain_diff = $signed({1'b0, target_q}) - $signed({1'b0, gain_q});
    if (in_valid) begin
      if (gain_diff > STEP_S) begin
        gain_d = gain_q + STEP_U;
      end else if (gain_diff < -STEP_S) begin
        gain_d = gain_q - STEP_U;
      end else begin
        gain_d = target_q;
      end
    end
  end

  // Two-stage datapath: multiply by the pre-ramp gain, then round and saturate
  always_comb begin
    vld1_d       = in_valid;
    prod_d       = prod_q;
    if (in_valid) begin
      prod_d = $signed({{17{in_sample[15]}}, in_sample}) * $signed({17'd0, gain_q});
    end
    rnd_sum      = {prod_q[32], prod_q} + 34'sd4096;
    rnd_shift    = rnd_sum >>> 13;
    out_vld_d    = vld1_q;
    out_sample_d = out_sample_q;
    clip_d       = 1'b0;
    if (vld1_q) begin
      if (rnd_shift > 34'sd32767) begin
        out_sample_d = 16'sh7FFF;
        clip_d       = 1'b1;
      end else if (rnd_shift < -34'sd32768) begin
        out_sample_d = -16'sh8000;
        clip_d       = 1'b1;
      end else begin
        out_sample_d = rnd_shift[15:0];
      end
    end
  end

  // Setting path registers; reset aborts any conversion in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      d2_q      <= 4'd0;
      d1_q      <= 4'd0;
      d0_q      <= 4'd0;
      neg_q     <= 1'b0;
      t_q       <= 10'd0;
      idx_q     <= 7'd0;
      target_q  <= GAIN_LUT[RESET_GAIN_IDX];
      bad_bcd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d2_q      <= d2_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      neg_q     <= neg_d;
      t_q       <= t_d;
      idx_q     <= idx_d;
      target_q  <= target_d;
      bad_bcd_q <= bad_bcd_d;
    end
  end

  // Ramp and datapath registers; reset discards samples in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gain_q       <= GAIN_LUT[RESET_GAIN_IDX];
      prod_q       <= 33'sd0;
      vld1_q       <= 1'b0;
      out_vld_q    <= 1'b0;
      out_sample_q <= 16'sd0;
      clip_q       <= 1'b0;
    end else begin
      gain_q       <= gain_d;
      prod_q       <= prod_d;
      vld1_q       <= vld1_d;
      out_vld_q    <= out_vld_d;
      out_sample_q <= out_sample_d;
      clip_q       <= clip_d;
    end
  end

  assign out_valid  = out_vld_q;
  assign out_sample = out_sample_q;
  assign clip       = clip_q;
  assign busy       = (state_q != S_IDLE);
  assign bad_bcd    = bad_bcd_q;
  assign gain       = gain_q;

endmodule

// File: tb/tb_output_gain_stage.sv
// Directed bench for output_gain_stage: hand-computed gains, ramp counts and outputs.
module tb_output_gain_stage;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               set;
  logic [3:0]         num2, num1, num0;
  logic               neg;
  logic               in_valid;
  logic signed [15:0] in_sample;
  logic               out_valid;
  logic signed [15:0] out_sample;
  logic               clip;
  logic               busy;
  logic               bad_bcd;
  logic [15:0]        gain;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  output_gain_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .set        (set),
    .num2       (num2),
    .num1       (num1),
    .num0       (num0),
    .neg        (neg),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .clip       (clip),
    .busy       (busy),
    .bad_bcd    (bad_bcd),
    .gain       (gain)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample in, check the strobe 2 cycles later and that it lasts 1 cycle
  task automatic send_chk(input string tag, input logic signed [15:0] s,
                          input int exp_out, input int exp_clip);
    in_sample = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_out"}, out_sample, exp_out);
    check({tag, "_clip"}, clip, exp_clip);
    tick();
    check({tag, "_vld_off"}, out_valid, 0);
  endtask

  task automatic ramp(input int n);
    in_sample = 16'sd0;
    in_valid  = 1'b1;
    repeat (n) tick();
    in_valid  = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_set(input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0, input logic ng);
    num2 = d2;
    num1 = d1;
    num0 = d0;
    neg  = ng;
    set  = 1'b1;
    tick();
    set  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    reset_n   = 1'b0;
    set       = 1'b0;
    num2      = 4'd0;
    num1      = 4'd0;
    num0      = 4'd0;
    neg       = 1'b0;
    in_valid  = 1'b0;
    in_sample = 16'sd0;
    #12;
    check("rst_vld", out_valid, 0);
    check("rst_out", out_sample, 0);
    check("rst_clip", clip, 0);
    check("rst_busy", busy, 0);
    check("rst_bad", bad_bcd, 0);
    check("rst_gain", gain, 8192);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();

    // 1: unity gain, latency and hold
    in_sample = 16'sd1000;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    check("t1_lat1", out_valid, 0);
    tick();
    check("t1_vld", out_valid, 1);
    check("t1_out", out_sample, 1000);
    check("t1_clip", clip, 0);
    tick();
    check("t1_vld_off", out_valid, 0);
    check("t1_hold", out_sample, 1000);

    // 2: +6.0 dB, busy for exactly 3 cycles, ramp of 510 samples
    do_set(4'd0, 4'd6, 4'd0, 1'b0);
    check("t2_busy_k", busy, 1);
    tick();
    tick();
    check("t2_busy_k2", busy, 1);
    tick();
    check("t2_busy_k3", busy, 0);
    ramp(1);
    check("t2_gain_1", gain, 8208);
    ramp(508);
    check("t2_gain_509", gain, 16336);
    ramp(1);
    check("t2_gain_510", gain, 16345);
    send_chk("t2", 16'sd1000, 1995, 0);

    // 3: +12.0 dB, positive and negative saturation
    do_set(4'd1, 4'd2, 4'd0, 1'b0);
    wait_idle("t3");
    ramp(1020);
    check("t3_gain", gain, 32613);
    send_chk("t3_pos", 16'sd20000, 32767, 1);
    send_chk("t3_neg", -16'sd20000, -32768, 1);
    send_chk("t3_mid", 16'sd8000, 31849, 0);

    // 4: -99.9 dB clamps to -60 dB; round-half-up at the output
    do_set(4'd9, 4'd9, 4'd9, 1'b1);
    wait_idle("t4");
    ramp(2040);
    check("t4_gain", gain, 8);
    send_chk("t4_max", 16'sd32767, 32, 0);
    send_chk("t4_half_p", 16'sd512, 1, 0);
    send_chk("t4_half_n", -16'sd512, 0, 0);

    // 5: bad digit, set while busy, then recovery
    do_set(4'd0, 4'hA, 4'd0, 1'b0);
    check("t5_bad_busy", busy, 1);
    tick();
    check("t5_bad_idle", busy, 0);
    check("t5_bad_flag", bad_bcd, 1);
    ramp(4);
    check("t5_target_kept", gain, 8);
    do_set(4'd0, 4'd0, 4'd5, 1'b1);
    num2 = 4'd1;
    num1 = 4'd2;
    num0 = 4'd0;
    neg  = 1'b0;
    set  = 1'b1;
    tick();
    set  = 1'b0;
    wait_idle("t5");
    check("t5_bad_clear", bad_bcd, 0);
    ramp(520);
    check("t5_gain_m05", gain, 8192);
    do_set(4'd0, 4'd0, 4'd5, 1'b0);
    wait_idle("t5p");
    ramp(70);
    check("t5_gain_p05", gain, 9192);
    do_set(4'd0, 4'd0, 4'd0, 1'b1);
    wait_idle("t5z");
    ramp(70);
    check("t5_gain_negzero", gain, 8192);

    // 6: async reset mid-ramp with samples streaming
    do_set(4'd1, 4'd2, 4'd0, 1'b0);
    wait_idle("t6");
    in_sample = 16'sd1000;
    in_valid  = 1'b1;
    repeat (30) tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_rst_vld", out_valid, 0);
    check("t6_rst_gain", gain, 8192);
    check("t6_rst_out", out_sample, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    stale = 0;
    repeat (4) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    check("t6_stale", stale, 0);
    check("t6_gain", gain, 8192);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
